// File: rtl/multi_port_mem_controller_pkg.sv
// Shared types and defaults for the multi-port line memory controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic {OP_READ, OP_WRITE} op_t;

  localparam int unsigned DEFAULT_NUM_PORTS      = 2;
  localparam int unsigned DEFAULT_LINE_BITS      = 128;
  localparam int unsigned DEFAULT_ADDR_BITS      = 26;
  localparam int unsigned DEFAULT_MEM_DEPTH_LOG2 = 10;
  localparam int unsigned DEFAULT_MEM_LATENCY    = 5;

  // Port index width; a single port still needs one bit to carry an index.
  function automatic int unsigned port_idx_bits(input int unsigned num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

endpackage

// File: rtl/multi_port_mem_controller_if.sv
// Cache-side request/response bundle; caches use master, the controller uses slave.
interface multi_port_mem_controller_if #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned LINE_BITS = 128,
  parameter int unsigned ADDR_BITS = 26
);

  logic [NUM_PORTS-1:0]                req_read;
  logic [NUM_PORTS-1:0]                req_write;
  logic [NUM_PORTS-1:0][ADDR_BITS-1:0] req_addr;
  logic [NUM_PORTS-1:0][LINE_BITS-1:0] req_wdata;
  logic [LINE_BITS-1:0]                rdata;
  logic [NUM_PORTS-1:0]                read_ready;
  logic [NUM_PORTS-1:0]                write_ack;
  logic                                busy;

  modport master (
    output req_read, req_write, req_addr, req_wdata,
    input  rdata, read_ready, write_ack, busy
  );

  modport slave (
    input  req_read, req_write, req_addr, req_wdata,
    output rdata, read_ready, write_ack, busy
  );

endinterface

// File: rtl/multi_port_mem_controller_rr_arbiter.sv
// Combinational round-robin arbiter: first pending port after last_idx wins.
module rr_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2
) (
  input  logic [NUM_PORTS-1:0]                    pending,
  input  logic [port_idx_bits(NUM_PORTS)-1:0]     last_idx,
  output logic [NUM_PORTS-1:0]                    grant,
  output logic [port_idx_bits(NUM_PORTS)-1:0]     grant_idx,
  output logic                                    any_grant
);

  localparam int unsigned IdxBits = port_idx_bits(NUM_PORTS);

  int unsigned idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
      idx = (32'(last_idx) + i) % NUM_PORTS;
      if (!any_grant && pending[idx[IdxBits-1:0]]) begin
        any_grant                 = 1'b1;
        grant[idx[IdxBits-1:0]]   = 1'b1;
        grant_idx                 = idx[IdxBits-1:0];
      end
    end
  end

endmodule

// File: rtl/multi_port_mem_controller.sv
// Line-wide backing store shared by NUM_PORTS caches, one round-robin transaction at a time.
module multi_port_mem_controller
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned NUM_PORTS      = DEFAULT_NUM_PORTS,
  parameter int unsigned LINE_BITS      = DEFAULT_LINE_BITS,
  parameter int unsigned ADDR_BITS      = DEFAULT_ADDR_BITS,
  parameter int unsigned MEM_DEPTH_LOG2 = DEFAULT_MEM_DEPTH_LOG2,
  parameter int unsigned MEM_LATENCY    = DEFAULT_MEM_LATENCY
) (
  input  logic                          clk,
  input  logic                          reset,
  multi_port_mem_controller_if.slave    bus
);

  localparam int unsigned IdxBits = port_idx_bits(NUM_PORTS);
  localparam int unsigned CntBits = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int unsigned Depth   = 1 << MEM_DEPTH_LOG2;

  state_t                    state_q, state_d;
  logic [CntBits-1:0]        cnt_q, cnt_d;
  logic [IdxBits-1:0]        gnt_q, gnt_d;
  logic [IdxBits-1:0]        rr_q, rr_d;
  op_t                       op_q, op_d;
  logic [MEM_DEPTH_LOG2-1:0] addr_q, addr_d;
  logic [LINE_BITS-1:0]      wdata_q, wdata_d;
  logic [LINE_BITS-1:0]      rdata_q;
  logic [NUM_PORTS-1:0]      read_ready_q, read_ready_d;
  logic [NUM_PORTS-1:0]      write_ack_q, write_ack_d;
  logic                      busy_q;
  logic                      do_access;

  logic [NUM_PORTS-1:0]      pending;
  logic [NUM_PORTS-1:0]      grant;
  logic [IdxBits-1:0]        grant_idx;
  logic                      any_grant;

  logic [LINE_BITS-1:0]      mem [Depth];

  assign pending = bus.req_read | bus.req_write;

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS)
  ) u_arb (
    .pending   (pending),
    .last_idx  (rr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    gnt_d        = gnt_q;
    rr_d         = rr_q;
    op_d         = op_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    read_ready_d = '0;
    write_ack_d  = '0;
    do_access    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_grant) begin
          gnt_d   = grant_idx;
          rr_d    = grant_idx;
          // Write-back goes ahead of refill when a port asks for both.
          op_d    = bus.req_write[grant_idx] ? OP_WRITE : OP_READ;
          addr_d  = bus.req_addr[grant_idx][MEM_DEPTH_LOG2-1:0];
          wdata_d = bus.req_wdata[grant_idx];
          cnt_d   = CntBits'(MEM_LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          do_access = 1'b1;
          state_d   = RESP;
          if (op_q == OP_WRITE) write_ack_d[gnt_q] = 1'b1;
          else                  read_ready_d[gnt_q] = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      gnt_q        <= '0;
      rr_q         <= IdxBits'(NUM_PORTS - 1);
      op_q         <= OP_READ;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      read_ready_q <= '0;
      write_ack_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      gnt_q        <= gnt_d;
      rr_q         <= rr_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      read_ready_q <= read_ready_d;
      write_ack_q  <= write_ack_d;
      busy_q       <= (state_d != IDLE);
      if (do_access && op_q == OP_READ) rdata_q <= mem[addr_q];
    end
  end

  // Storage is not reset; an aborted transaction never reaches WAIT's access point.
  always_ff @(posedge clk) begin
    if (do_access && op_q == OP_WRITE) mem[addr_q] <= wdata_q;
  end

  assign bus.rdata      = rdata_q;
  assign bus.read_ready = read_ready_q;
  assign bus.write_ack  = write_ack_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_multi_port_mem_controller.sv
// Directed scoreboard bench: a 2-port/latency-5 and a 4-port/latency-1 controller.
module tb_multi_port_mem_controller;

  typedef struct {
    bit           is_write;
    int           port;
    logic [127:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   c;
  logic b1;
  exp_t q2[$];
  exp_t q4[$];
  exp_t e2;
  exp_t e4;

  localparam logic [127:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] DA = {16{8'hAA}};
  localparam logic [127:0] DP = 128'hDEADBEEF_00000000_CAFEF00D_12345678;
  localparam logic [127:0] DQ = 128'h55555555_66666666_77777777_88888888;

  always #5 clk = ~clk;

  multi_port_mem_controller_if #(.NUM_PORTS(2), .LINE_BITS(128), .ADDR_BITS(26)) b2 ();
  multi_port_mem_controller_if #(.NUM_PORTS(4), .LINE_BITS(128), .ADDR_BITS(26)) b4 ();

  multi_port_mem_controller #(
    .NUM_PORTS(2), .LINE_BITS(128), .ADDR_BITS(26), .MEM_DEPTH_LOG2(10), .MEM_LATENCY(5)
  ) dut2 (
    .clk   (clk),
    .reset (rst_n),
    .bus   (b2)
  );

  multi_port_mem_controller #(
    .NUM_PORTS(4), .LINE_BITS(128), .ADDR_BITS(26), .MEM_DEPTH_LOG2(10), .MEM_LATENCY(1)
  ) dut4 (
    .clk   (clk),
    .reset (rst_n),
    .bus   (b4)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait2(input int max, output int cyc, output logic busy1);
    cyc   = 0;
    busy1 = 1'b0;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (i == 1) busy1 = b2.busy;
      if (b2.read_ready != '0 || b2.write_ack != '0) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic wait4(input int max, output int cyc);
    cyc = 0;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (b4.read_ready != '0 || b4.write_ack != '0) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n && (b2.read_ready != '0 || b2.write_ack != '0)) begin
      if (q2.size() == 0) begin
        check("sb2_spurious", 128'({b2.read_ready, b2.write_ack}), 128'(0));
      end else begin
        e2 = q2.pop_front();
        check("sb2_ack", 128'(b2.write_ack), e2.is_write ? (128'(1) << e2.port) : 128'(0));
        check("sb2_ready", 128'(b2.read_ready), e2.is_write ? 128'(0) : (128'(1) << e2.port));
        if (!e2.is_write) check("sb2_rdata", b2.rdata, e2.data);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && (b4.read_ready != '0 || b4.write_ack != '0)) begin
      if (q4.size() == 0) begin
        check("sb4_spurious", 128'({b4.read_ready, b4.write_ack}), 128'(0));
      end else begin
        e4 = q4.pop_front();
        check("sb4_ack", 128'(b4.write_ack), e4.is_write ? (128'(1) << e4.port) : 128'(0));
        check("sb4_ready", 128'(b4.read_ready), e4.is_write ? 128'(0) : (128'(1) << e4.port));
        if (!e4.is_write) check("sb4_rdata", b4.rdata, e4.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    b2.req_read  = '0;
    b2.req_write = '0;
    b2.req_addr  = '0;
    b2.req_wdata = '0;
    b4.req_read  = '0;
    b4.req_write = '0;
    b4.req_addr  = '0;
    b4.req_wdata = '0;
    repeat (2) @(negedge clk);
    check("rst2_rdata", b2.rdata, 128'(0));
    check("rst2_ready", 128'(b2.read_ready), 128'(0));
    check("rst2_ack", 128'(b2.write_ack), 128'(0));
    check("rst2_busy", 128'(b2.busy), 128'(0));
    check("rst4_rdata", b4.rdata, 128'(0));
    check("rst4_busy", 128'(b4.busy), 128'(0));
    rst_n = 1'b1;

    // Single write then read on port 0.
    @(negedge clk);
    b2.req_addr[0]  = 26'h0000005;
    b2.req_wdata[0] = D1;
    b2.req_write[0] = 1'b1;
    q2.push_back('{1'b1, 0, '0});
    wait2(20, c, b1);
    check("t1_wr_cycle", 128'(c), 128'(6));
    check("t1_busy_wait", 128'(b1), 128'(1));
    check("t1_busy_resp", 128'(b2.busy), 128'(1));
    b2.req_write[0] = 1'b0;
    @(negedge clk);
    check("t1_busy_idle", 128'(b2.busy), 128'(0));
    b2.req_read[0] = 1'b1;
    q2.push_back('{1'b0, 0, D1});
    wait2(20, c, b1);
    check("t1_rd_cycle", 128'(c), 128'(6));
    b2.req_read[0] = 1'b0;

    // Simultaneous reads after reset; port 1 reads an alias of line 5.
    reset_pulse();
    for (int rep = 0; rep < 2; rep++) begin
      b2.req_addr[0] = 26'h0000005;
      b2.req_addr[1] = 26'h0000405;
      b2.req_read    = 2'b11;
      q2.push_back('{1'b0, 0, D1});
      q2.push_back('{1'b0, 1, D1});
      wait2(20, c, b1);
      check("t2_p0_cycle", 128'(c), 128'(6));
      b2.req_read[0] = 1'b0;
      wait2(20, c, b1);
      check("t2_p1_gap", 128'(c), 128'(7));
      b2.req_read[1] = 1'b0;
      @(negedge clk);
    end

    // Port 1 write-back and refill together: write served first.
    b2.req_addr[1]  = 26'h0000010;
    b2.req_wdata[1] = DA;
    b2.req_write[1] = 1'b1;
    b2.req_read[1]  = 1'b1;
    q2.push_back('{1'b1, 1, '0});
    q2.push_back('{1'b0, 1, DA});
    wait2(20, c, b1);
    check("t3_wr_cycle", 128'(c), 128'(6));
    b2.req_write[1] = 1'b0;
    wait2(20, c, b1);
    check("t3_rd_gap", 128'(c), 128'(7));
    b2.req_read[1] = 1'b0;

    // Upper address bits alias onto the same line.
    @(negedge clk);
    b2.req_addr[0]  = 26'h0000401;
    b2.req_wdata[0] = 128'h1;
    b2.req_write[0] = 1'b1;
    q2.push_back('{1'b1, 0, '0});
    wait2(20, c, b1);
    check("t4_wr_cycle", 128'(c), 128'(6));
    b2.req_write[0] = 1'b0;
    @(negedge clk);
    b2.req_addr[1] = 26'h0000001;
    b2.req_read[1] = 1'b1;
    q2.push_back('{1'b0, 1, 128'h1});
    wait2(20, c, b1);
    check("t4_rd_cycle", 128'(c), 128'(6));
    b2.req_read[1] = 1'b0;

    // Reset during WAIT of a write must leave the line untouched.
    @(negedge clk);
    b2.req_addr[0]  = 26'h0000020;
    b2.req_wdata[0] = DP;
    b2.req_write[0] = 1'b1;
    q2.push_back('{1'b1, 0, '0});
    wait2(20, c, b1);
    check("t5_pre_cycle", 128'(c), 128'(6));
    b2.req_write[0] = 1'b0;
    @(negedge clk);
    b2.req_wdata[0] = DQ;
    b2.req_write[0] = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_busy_wait", 128'(b2.busy), 128'(1));
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", 128'(b2.busy), 128'(0));
    check("t5_rst_rdata", b2.rdata, 128'(0));
    check("t5_rst_pulses", 128'({b2.read_ready, b2.write_ack}), 128'(0));
    b2.req_write[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    b2.req_read[0] = 1'b1;
    q2.push_back('{1'b0, 0, DP});
    wait2(20, c, b1);
    check("t5_rd_cycle", 128'(c), 128'(6));
    b2.req_read[0] = 1'b0;
    @(negedge clk);

    // Four ports, latency 1: preload lines 0..3, then all ports read continuously.
    for (int i = 0; i < 4; i++) begin
      b4.req_addr[0]  = 26'(i);
      b4.req_wdata[0] = 128'h100 + 128'(i);
      b4.req_write[0] = 1'b1;
      q4.push_back('{1'b1, 0, '0});
      wait4(10, c);
      check("t6_pre_cycle", 128'(c), 128'(2));
      b4.req_write[0] = 1'b0;
      @(negedge clk);
    end
    reset_pulse();
    for (int p = 0; p < 4; p++) b4.req_addr[p] = 26'(p);
    b4.req_read = 4'b1111;
    for (int k = 0; k < 5; k++) q4.push_back('{1'b0, k % 4, 128'h100 + 128'(k % 4)});
    for (int k = 0; k < 5; k++) begin
      wait4(10, c);
      check("t6_rr_period", 128'(c), (k == 0) ? 128'(2) : 128'(3));
    end
    b4.req_read = 4'b0000;
    repeat (6) @(negedge clk);

    check("sb2_drained", 128'(q2.size()), 128'(0));
    check("sb4_drained", 128'(q4.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_port_mem_controller.md
Name: multi_port_mem_controller

Overview:
- Parametrised successor to the fixed two-requester (icache/dcache) memory controller: serves NUM_PORTS cache clients, each issuing line reads (refill) and line writes (write-back).
- Round-robin arbitration, one transaction in flight, programmable access latency, internal line-wide backing store.
- Sits between the L1 caches and the memory model in the cache test top and, later, the core top.

Parameters:
- NUM_PORTS, 2, number of requesting caches (>=1).
- LINE_BITS, 128, cache line width in bits.
- ADDR_BITS, 26, line address width.
- MEM_DEPTH_LOG2, 10, log2 of backing-store lines; indexed by req_addr[p][MEM_DEPTH_LOG2-1:0].
- MEM_LATENCY, 5, wait cycles between grant and response (>=1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_read  in  NUM_PORTS  per-port line read request, level, held until read_ready.
- req_write  in  NUM_PORTS  per-port line write request, level, held until write_ack.
- req_addr  in  NUM_PORTS x ADDR_BITS  per-port line address, stable while any req of that port is high.
- req_wdata  in  NUM_PORTS x LINE_BITS  per-port write line, stable while req_write high.
- rdata  out  LINE_BITS  shared read data; valid in the read_ready cycle, held until the next read response.
- read_ready  out  NUM_PORTS  one-hot single-cycle read completion pulse.
- write_ack  out  NUM_PORTS  one-hot single-cycle write completion pulse.
- busy  out  1  high whenever FSM is not IDLE.

Behaviour:
- Reset (reset=0, async): state=IDLE, rdata=0, read_ready=0, write_ack=0, busy=0, counter=0, rr pointer=NUM_PORTS-1 (port 0 wins first). Backing-store contents are not reset. Reset mid-transaction aborts it with no pulse and no memory write.
- FSM IDLE -> WAIT -> RESP -> IDLE. All outputs are registered.
- IDLE: pending[p] = req_read[p] | req_write[p]. If any pending, grant the first pending port searching from rr_ptr+1 modulo NUM_PORTS. Latch the port index, op, address and wdata. rr_ptr <= granted port. Counter <= MEM_LATENCY-1. Go to WAIT.
- Op select: if granted port has both req_write and req_read high, serve the write first (write-back before refill). The read is served on a later grant.
- WAIT: decrement counter. At 0, perform the access and go to RESP. Write: mem[idx] <= wdata. Read: rdata <= mem[idx].
- RESP: exactly one of read_ready[g]/write_ack[g] high for one cycle. Next state IDLE.
- Timing: request first sampled at edge 0 with FSM idle -> pulse high during cycle MEM_LATENCY+1. Back-to-back turnaround is one IDLE cycle.
- Requester protocol: drop the served req on the edge ending the pulse cycle. A req still high in IDLE is treated as a new request.
- Requests arriving while busy wait. No starvation: each port is served within NUM_PORTS grants.
- Upper address bits above MEM_DEPTH_LOG2 are ignored (aliasing is intended).
- Read-after-write to the same line returns the new data (accesses are serialised).
- NUM_PORTS=1: the arbiter degenerates to pass-through and the rr pointer stays 0.

Decomposition:
- Package mem_ctrl_pkg: state_t enum {IDLE, WAIT, RESP}, op_t enum {OP_READ, OP_WRITE}, default parameter constants, and a clog2-based PORT_IDX_BITS helper.
- Sub-module rr_arbiter (NUM_PORTS): inputs pending vector and last-grant index; outputs one-hot grant, grant index and any_grant. Combinational, instantiated once.
- The controller holds the FSM, latency counter, latches and storage array.

Test Plan:
- Single write then read, port 0, addr 0x0000005, wdata 0x0123..CDEF: write_ack[0] in cycle 6, then read_ready[0] with rdata equal to the written line; busy high throughout WAIT/RESP.
- Simultaneous reads on ports 0 and 1 after reset -> port 0 served first (ready cycle 6), port 1 next (ready cycle 13); repeat -> order again 0 then 1 with rr pointer rotating.
- Port 1 asserts req_write and req_read together for addr 0x10 with wdata 0xAA..AA -> write_ack[1] precedes read_ready[1], and rdata=0xAA..AA.
- Aliasing: write 0x1 to addr 0x0000401 and read addr 0x0000001 (MEM_DEPTH_LOG2=10) -> rdata=0x1.
- Reset asserted during WAIT of a write to addr 0x20 -> all outputs 0 immediately, no ack; a post-reset read of 0x20 returns the pre-existing content.
- NUM_PORTS=4, MEM_LATENCY=1, all four ports continuously requesting reads -> grants 0,1,2,3,0 in order, with one pulse every 3 cycles.
